// File: rtl/flash_trigger.sv
// Button-to-flash request: sync, debounce, rising-edge detect, fixed-width FLSH pulse.
// Build option FLASH_RETRIGGER_EN: a press during HOLD restarts the pulse and is counted.
module flash_trigger #(
    parameter int unsigned DB_CYCLES   = 1_000_000,
    parameter int unsigned HOLD_CYCLES = 200_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       FLSH,
    output logic [7:0] PRESS_CNT
);

    localparam int unsigned DW = $clog2(DB_CYCLES + 1);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    state_t        state;
    logic          press;

    // Two-flop synchronizer on the raw button
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
        end
    end

    // A new level is accepted only after DB_CYCLES consecutive differing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            stable   <= 1'b0;
            stable_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            stable_d <= stable;
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign press = stable & ~stable_d;

    // Pulse FSM: hold_cnt counts down the remaining HOLD cycles after the first
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            PRESS_CNT <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        state     <= HOLD;
                        hold_cnt  <= HW'(HOLD_CYCLES - 1);
                        PRESS_CNT <= PRESS_CNT + 8'd1;
                    end
                end
                HOLD: begin
`ifdef FLASH_RETRIGGER_EN
                    if (press) begin
                        hold_cnt  <= HW'(HOLD_CYCLES - 1);
                        PRESS_CNT <= PRESS_CNT + 8'd1;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else begin
                        state <= IDLE;
                    end
`else
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else begin
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign FLSH = (state == HOLD);

endmodule

// File: tb/tb_flash_trigger.sv
// Self-checking bench for flash_trigger (DB_CYCLES=4, HOLD_CYCLES=10): vector table,
// corner-case sequences and random button activity against a cycle-count reference model.
module tb_flash_trigger;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = 10;
`ifdef FLASH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       BTN;
    logic       FLSH;
    logic [7:0] PRESS_CNT;

    flash_trigger #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN      (BTN),
        .FLSH     (FLSH),
        .PRESS_CNT(PRESS_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: sample pipeline, run length of disagreeing samples,
    // remaining high cycles of the flash pulse, and press count.
    logic       m_p1 = 1'b0, m_p2 = 1'b0;
    logic       m_lvl = 1'b0, m_lvl_prev = 1'b0;
    int         m_run = 0;
    int         m_left = 0;
    logic [7:0] m_cnt = 8'd0;

    typedef struct {
        logic       rst;
        logic       btn;
        int         n;
        logic       flsh;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic b);
        logic s2_old, lvl_old, press_old;
        if (r) begin
            m_p1 = 1'b0; m_p2 = 1'b0; m_lvl = 1'b0; m_lvl_prev = 1'b0;
            m_run = 0; m_left = 0; m_cnt = 8'd0;
        end else begin
            s2_old    = m_p2;
            lvl_old   = m_lvl;
            press_old = m_lvl & ~m_lvl_prev;
            m_p2 = m_p1;
            m_p1 = b;
            if (s2_old != lvl_old) begin
                m_run++;
                if (m_run == int'(DB)) begin
                    m_lvl = s2_old;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_lvl_prev = lvl_old;
            if (press_old && (m_left == 0 || RETRIG)) begin
                m_left = int'(HOLD);
                m_cnt  = m_cnt + 8'd1;
            end else if (m_left != 0) begin
                m_left--;
            end
        end
    endtask

    task automatic step(input logic r, input logic b);
        RST = r;
        BTN = b;
        @(posedge CLK);
        model_edge(r, b);
        #1;
        chk("model_flsh", 32'(FLSH), 32'(m_left != 0));
        chk("model_cnt", 32'(PRESS_CNT), 32'(m_cnt));
    endtask

    task automatic apply(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) step(r, b);
    endtask

    // Second rise lands at edge rise_at; first press enters HOLD at edge 6.
    task automatic retrig_seq(input int rise_at, input int hi_last, input int cnt_add,
                              input string nm);
        logic [7:0] exp8;
        exp8 = m_cnt + 8'(cnt_add);
        for (int e = 0; e <= 40; e++) begin
            step(1'b0, (e < 4) || (e >= rise_at));
            chk({nm, "_flsh"}, 32'(FLSH), 32'(e >= 6 && e <= hi_last));
        end
        chk({nm, "_cnt"}, 32'(PRESS_CNT), 32'(exp8));
        apply(1'b0, 1'b0, 20);
    endtask

    initial begin
        RST = 1'b1;
        BTN = 1'b1;

        // reset with button held, two clean presses, bounce, short glitch
        tbl[0]  = '{1'b1, 1'b1, 3,  1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 6,  1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1,  1'b1, 8'd1};
        tbl[3]  = '{1'b0, 1'b1, 9,  1'b1, 8'd1};
        tbl[4]  = '{1'b0, 1'b1, 1,  1'b0, 8'd1};
        tbl[5]  = '{1'b0, 1'b0, 20, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 1'b1, 6,  1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 1,  1'b1, 8'd2};
        tbl[8]  = '{1'b0, 1'b1, 9,  1'b1, 8'd2};
        tbl[9]  = '{1'b0, 1'b1, 1,  1'b0, 8'd2};
        tbl[10] = '{1'b0, 1'b0, 20, 1'b0, 8'd2};
        tbl[11] = '{1'b0, 1'b1, 1,  1'b0, 8'd2};
        tbl[12] = '{1'b0, 1'b0, 1,  1'b0, 8'd2};
        tbl[13] = '{1'b0, 1'b1, 1,  1'b0, 8'd2};
        tbl[14] = '{1'b0, 1'b0, 1,  1'b0, 8'd2};
        tbl[15] = '{1'b0, 1'b1, 1,  1'b0, 8'd2};
        tbl[16] = '{1'b0, 1'b1, 5,  1'b0, 8'd2};
        tbl[17] = '{1'b0, 1'b1, 1,  1'b1, 8'd3};
        tbl[18] = '{1'b0, 1'b1, 9,  1'b1, 8'd3};
        tbl[19] = '{1'b0, 1'b1, 1,  1'b0, 8'd3};
        tbl[20] = '{1'b0, 1'b0, 20, 1'b0, 8'd3};
        tbl[21] = '{1'b0, 1'b1, 3,  1'b0, 8'd3};
        tbl[22] = '{1'b0, 1'b0, 20, 1'b0, 8'd3};

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].rst, tbl[i].btn, tbl[i].n);
            chk($sformatf("row%0d_flsh", i), 32'(FLSH), 32'(tbl[i].flsh));
            chk($sformatf("row%0d_cnt", i), 32'(PRESS_CNT), 32'(tbl[i].cnt));
        end

        // earliest reachable second press (hold_cnt=2), then press on the hold_cnt==0 cycle
        retrig_seq(8,  RETRIG ? 23 : 15, RETRIG ? 2 : 1, "retrig_mid");
        retrig_seq(10, RETRIG ? 25 : 15, RETRIG ? 2 : 1, "retrig_last");

        // reset pulse while hold_cnt=5, button low
        for (int e = 0; e <= 11; e++) begin
            step(e == 11, e < 4);
            if (e == 10) chk("rst_hold_pre", 32'(FLSH), 32'd1);
        end
        chk("rst_hold_flsh", 32'(FLSH), 32'd0);
        chk("rst_hold_cnt", 32'(PRESS_CNT), 32'd0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0);
            chk("rst_hold_quiet", 32'(FLSH), 32'd0);
        end

        // press counter wrap
        apply(1'b1, 1'b0, 2);
        for (int k = 1; k <= 256; k++) begin
            apply(1'b0, 1'b1, 6);
            apply(1'b0, 1'b0, 10);
            if (k == 255) chk("wrap_255", 32'(PRESS_CNT), 32'd255);
            if (k == 256) chk("wrap_256", 32'(PRESS_CNT), 32'd0);
        end

        // random button activity with occasional resets
        apply(1'b1, 1'b0, 2);
        for (int i = 0; i < 3000; ) begin
            logic b;
            int   n;
            b = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 20))
                                             : int'($urandom_range(1, 6));
            if ($urandom_range(0, 99) == 0) apply(1'b1, b, 1);
            apply(1'b0, b, n);
            i += n;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
